nn_mul_arbiter: RTL and testbench

Round-robin arbiter and sequencer that time-shares a single unsigned multiplier (6-bit x 5-bit, 10-bit truncated product by default) among NUM_REQ requesters in the NN datapath. Each requester presents an operand pair with a valid/ready handshake. The block grants one requester per cycle, multiplies the operands combinationally, and registers the product together with the requester ID on a single response channel. It sits between the layer-loop engines and the shared multiplier resource, replacing per-engine multiplier instances.

---
 rtl/nn_mul_arb_pkg.sv | 36 +++
 rtl/nn_mul_core.sv | 18 +
 rtl/nn_mul_arbiter.sv | 107 ++++++++++
 tb/tb_nn_mul_arbiter.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/nn_mul_arb_pkg.sv
// Shared types and helpers for the NN multiplier arbiter: ID sizing and
// the rotating-priority grant search.
package nn_mul_arb_pkg;

  localparam int MAX_REQ   = 16;
  localparam int MAX_IDX_W = 4;

  typedef struct packed {
    logic                 any;
    logic [MAX_IDX_W-1:0] idx;
    logic [MAX_REQ-1:0]   onehot;
  } grant_t;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Scan last+1, last+2, ... modulo n; first valid requester wins.
  function automatic grant_t rr_pick(input logic [MAX_REQ-1:0]   valid,
                                     input logic [MAX_IDX_W-1:0] last,
                                     input int                   n);
    grant_t               g;
    logic [MAX_IDX_W-1:0] idx;
    g = '0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      idx = MAX_IDX_W'((int'(last) + k) % n);
      if (k <= n && !g.any && valid[idx]) begin
        g.any         = 1'b1;
        g.idx         = idx;
        g.onehot[idx] = 1'b1;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/nn_mul_core.sv
// Combinational unsigned multiplier; kept separate so a DSP-mapped
// implementation can be dropped in without touching the arbiter.
module nn_mul_core #(
  parameter int A_WIDTH = 6,
  parameter int B_WIDTH = 5,
  parameter int P_WIDTH = 10
) (
  input  logic [A_WIDTH-1:0] a,
  input  logic [B_WIDTH-1:0] b,
  output logic [P_WIDTH-1:0] p
);

  logic [A_WIDTH+B_WIDTH-1:0] full;

  assign full = {{B_WIDTH{1'b0}}, a} * {{A_WIDTH{1'b0}}, b};
  assign p    = full[P_WIDTH-1:0];

endmodule

// File: rtl/nn_mul_arbiter.sv
// Round-robin arbiter time-sharing one multiplier among NUM_REQ requesters,
// with a single registered response stage.
module nn_mul_arbiter
  import nn_mul_arb_pkg::*;
#(
  parameter int  NUM_REQ  = 4,
  parameter int  A_WIDTH  = 6,
  parameter int  B_WIDTH  = 5,
  parameter int  P_WIDTH  = 10,
  localparam int ID_WIDTH = id_width(NUM_REQ)
) (
  input  logic                       ap_clk,
  input  logic                       ap_rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*A_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*B_WIDTH-1:0] req_b,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [P_WIDTH-1:0]         rsp_p,
  output logic [ID_WIDTH-1:0]        rsp_id,
  output logic [31:0]                done_cnt
);

  logic                rsp_valid_reg;
  logic [P_WIDTH-1:0]  rsp_p_reg;
  logic [ID_WIDTH-1:0] rsp_id_reg;
  logic [ID_WIDTH-1:0] last_grant_reg;
  logic [31:0]         done_cnt_reg;

  logic [MAX_REQ-1:0]  valid_ext;
  grant_t              pick;
  logic                can_accept;
  logic                accept;
  logic [A_WIDTH-1:0]  a_masked [NUM_REQ];
  logic [B_WIDTH-1:0]  b_masked [NUM_REQ];
  logic [A_WIDTH-1:0]  gnt_a;
  logic [B_WIDTH-1:0]  gnt_b;
  logic [P_WIDTH-1:0]  prod;
  logic                unused_pick;

  always_comb begin
    valid_ext                = '0;
    valid_ext[NUM_REQ-1:0]   = req_valid;
  end

  assign pick        = rr_pick(valid_ext, MAX_IDX_W'(last_grant_reg), NUM_REQ);
  assign unused_pick = ^pick;
  assign can_accept  = !rsp_valid_reg | rsp_ready;
  assign accept      = can_accept & pick.any;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign req_ready[gi] = can_accept & pick.onehot[gi];
      assign a_masked[gi]  = pick.onehot[gi] ? req_a[gi*A_WIDTH +: A_WIDTH] : '0;
      assign b_masked[gi]  = pick.onehot[gi] ? req_b[gi*B_WIDTH +: B_WIDTH] : '0;
    end
  endgenerate

  // Grant is one-hot, so OR-combining the masked operands forms the mux.
  always_comb begin
    gnt_a = '0;
    gnt_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      gnt_a = gnt_a | a_masked[i];
      gnt_b = gnt_b | b_masked[i];
    end
  end

  nn_mul_core #(
    .A_WIDTH (A_WIDTH),
    .B_WIDTH (B_WIDTH),
    .P_WIDTH (P_WIDTH)
  ) u_core (
    .a (gnt_a),
    .b (gnt_b),
    .p (prod)
  );

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      rsp_valid_reg  <= 1'b0;
      rsp_p_reg      <= '0;
      rsp_id_reg     <= '0;
      last_grant_reg <= ID_WIDTH'(NUM_REQ - 1);
      done_cnt_reg   <= '0;
    end else begin
      if (rsp_valid_reg && rsp_ready) begin
        done_cnt_reg <= done_cnt_reg + 32'd1;
      end
      if (accept) begin
        rsp_valid_reg  <= 1'b1;
        rsp_p_reg      <= prod;
        rsp_id_reg     <= pick.idx[ID_WIDTH-1:0];
        last_grant_reg <= pick.idx[ID_WIDTH-1:0];
      end else if (rsp_ready) begin
        rsp_valid_reg  <= 1'b0;
      end
    end
  end

  assign rsp_valid = rsp_valid_reg;
  assign rsp_p     = rsp_p_reg;
  assign rsp_id    = rsp_id_reg;
  assign done_cnt  = done_cnt_reg;

endmodule

// File: tb/tb_nn_mul_arbiter.sv
// Directed self-checking bench for nn_mul_arbiter (default 4 x 6b x 5b).
module tb_nn_mul_arbiter;

  localparam int NUM_REQ = 4;
  localparam int A_WIDTH = 6;
  localparam int B_WIDTH = 5;
  localparam int P_WIDTH = 10;
  localparam int ID_WIDTH = 2;

  logic                       ap_clk;
  logic                       ap_rst_n;
  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ-1:0]         req_ready;
  logic [NUM_REQ*A_WIDTH-1:0] req_a;
  logic [NUM_REQ*B_WIDTH-1:0] req_b;
  logic                       rsp_valid;
  logic                       rsp_ready;
  logic [P_WIDTH-1:0]         rsp_p;
  logic [ID_WIDTH-1:0]        rsp_id;
  logic [31:0]                done_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  nn_mul_arbiter #(
    .NUM_REQ (NUM_REQ),
    .A_WIDTH (A_WIDTH),
    .B_WIDTH (B_WIDTH),
    .P_WIDTH (P_WIDTH)
  ) dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_p     (rsp_p),
    .rsp_id    (rsp_id),
    .done_cnt  (done_cnt)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("check %-16s got=%0d exp=%0d ok", tag, got, exp);
    end else begin
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic set_req(input int i, input int a, input int b);
    req_valid[i] = 1'b1;
    req_a[i*A_WIDTH +: A_WIDTH] = A_WIDTH'(a);
    req_b[i*B_WIDTH +: B_WIDTH] = B_WIDTH'(b);
  endtask

  initial begin
    ap_rst_n  = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    step();
    step();
    check("rst_valid", 32'(rsp_valid), 0);
    check("rst_p", 32'(rsp_p), 0);
    check("rst_id", 32'(rsp_id), 0);
    check("rst_done", done_cnt, 0);
    check("rst_ready", 32'(req_ready), 0);
    #2 ap_rst_n = 1'b1;
    step();

    // Single request from requester 2: 37*19 = 703.
    set_req(2, 37, 19);
    #1 check("single_rdy", 32'(req_ready), 32'b0100);
    step();
    req_valid = '0;
    check("single_valid", 32'(rsp_valid), 1);
    check("single_p", 32'(rsp_p), 703);
    check("single_id", 32'(rsp_id), 2);
    step();
    check("single_done", done_cnt, 1);
    check("single_drain", 32'(rsp_valid), 0);

    // Truncation via requester 3 (search starts at 3): 63*31=1953 -> 929.
    set_req(3, 63, 31);
    #1 check("trunc_rdy", 32'(req_ready), 32'b1000);
    step();
    req_valid = '0;
    check("trunc_p", 32'(rsp_p), 929);
    check("trunc_id", 32'(rsp_id), 3);
    step();
    check("trunc_done", done_cnt, 2);

    // Round-robin, all valid; requester i uses a=10+i, b=3+i.
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 10 + i, 3 + i);
    for (int k = 0; k < 8; k++) begin
      #1 check($sformatf("rr_rdy%0d", k), 32'(req_ready), 32'(1 << (k % 4)));
      step();
      check($sformatf("rr_id%0d", k), 32'(rsp_id), 32'(k % 4));
      check($sformatf("rr_p%0d", k), 32'(rsp_p), 32'(((10 + k % 4) * (3 + k % 4)) % 1024));
      check($sformatf("rr_v%0d", k), 32'(rsp_valid), 1);
    end
    check("rr_done", done_cnt, 9);

    // Backpressure: id3 product 13*6=78 held, requesters 1 and 3 waiting.
    req_valid = 4'b1010;
    rsp_ready = 1'b0;
    #1 check("bp_rdy0", 32'(req_ready), 0);
    for (int k = 0; k < 5; k++) begin
      step();
      check($sformatf("bp_rdy%0d", k + 1), 32'(req_ready), 0);
      check($sformatf("bp_p%0d", k), 32'(rsp_p), 78);
      check($sformatf("bp_id%0d", k), 32'(rsp_id), 3);
      check($sformatf("bp_v%0d", k), 32'(rsp_valid), 1);
    end
    check("bp_done_hold", done_cnt, 9);
    rsp_ready = 1'b1;
    #1 check("bp_release_rdy", 32'(req_ready), 32'b0010);
    step();
    check("bp_next_id", 32'(rsp_id), 1);
    check("bp_next_p", 32'(rsp_p), 44);
    check("bp_done", done_cnt, 10);

    // Idle cycles must not rotate priority away from last grant (1).
    req_valid = '0;
    step();
    step();
    step();
    check("idle_valid", 32'(rsp_valid), 0);
    check("idle_done", done_cnt, 11);
    req_valid = 4'b0101;
    #1 check("idle_rdy", 32'(req_ready), 32'b0100);
    step();
    check("idle_id", 32'(rsp_id), 2);
    check("idle_p", 32'(rsp_p), 60);

    // Asynchronous reset between edges while a product is pending.
    req_valid = '0;
    rsp_ready = 1'b0;
    #2 ap_rst_n = 1'b0;
    #1 check("arst_valid", 32'(rsp_valid), 0);
    check("arst_done", done_cnt, 0);
    check("arst_id", 32'(rsp_id), 0);
    #1 ap_rst_n = 1'b1;
    rsp_ready = 1'b1;
    req_valid = 4'b1010;
    #1 check("arst_rdy", 32'(req_ready), 32'b0010);
    step();
    check("arst_gnt_id", 32'(rsp_id), 1);
    check("arst_gnt_p", 32'(rsp_p), 44);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
